// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds, flushes or loads the fetched instruction.
// Optional fetch address-error check is enabled by defining IF_ID_FETCH_EXC_EN.
module if_id_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        xstall,
  input  logic        flush,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc_f,
  input  logic        is_jump_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        bd_d,
  output logic [4:0]  exccode_d,
  output logic        valid_d
);

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_LO    = 32'h0000_3000;
  localparam logic [31:0] PC_HI    = 32'h0000_4FFC;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        bd;
    logic [4:0]  exc;
    logic        valid;
  } if_id_t;

  if_id_t      r_q;
  if_id_t      w_load;
  if_id_t      w_bubble;
  if_id_t      w_rst;
  logic        w_hold;
  logic        w_adel;
  logic [31:0] w_pc8;

  assign w_hold = stall | xstall;
  assign w_pc8  = pc_f + 32'd8;

`ifdef IF_ID_FETCH_EXC_EN
  assign w_adel = (pc_f[1:0] != 2'b00)
                | (pc_f < PC_LO)
                | (pc_f > PC_HI);
`else
  assign w_adel = 1'b0;
`endif

  // A faulting fetch is turned into a nop that carries AdEL down the pipe.
  always_comb begin
    w_load       = '0;
    w_load.instr = w_adel ? NOP : instr_f;
    w_load.pc    = pc_f;
    w_load.pc8   = w_pc8;
    w_load.bd    = is_jump_d;
    w_load.exc   = w_adel ? EXC_ADEL : 5'd0;
    w_load.valid = 1'b1;
  end

  always_comb begin
    w_bubble       = '0;
    w_bubble.instr = NOP;
    w_bubble.pc    = pc_f;
    w_bubble.pc8   = w_pc8;
  end

  always_comb begin
    w_rst     = '0;
    w_rst.pc  = PC_RESET;
    w_rst.pc8 = PC_RESET + 32'd8;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= w_rst;
    end else if (flush) begin
      r_q <= w_bubble;
    end else if (!w_hold) begin
      r_q <= w_load;
    end
  end

  assign instr_d   = r_q.instr;
  assign pc_d      = r_q.pc;
  assign pc8_d     = r_q.pc8;
  assign bd_d      = r_q.bd;
  assign valid_d   = r_q.valid;
`ifdef IF_ID_FETCH_EXC_EN
  assign exccode_d = r_q.exc;
`else
  assign exccode_d = 5'd0;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboard bench for if_id_reg; expectations follow IF_ID_FETCH_EXC_EN.
module tb_if_id_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        bd;
    logic [4:0]  exc;
    logic        valid;
  } exp_t;

`ifdef IF_ID_FETCH_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clk;
  logic        reset, stall, xstall, flush, is_jump_d;
  logic [31:0] instr_f, pc_f;
  logic [31:0] instr_d, pc_d, pc8_d;
  logic        bd_d, valid_d;
  logic [4:0]  exccode_d;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;

  if_id_reg dut (
    .clk(clk), .reset(reset), .stall(stall),
    .xstall(xstall), .flush(flush),
    .instr_f(instr_f), .pc_f(pc_f),
    .is_jump_d(is_jump_d),
    .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d),
    .bd_d(bd_d), .exccode_d(exccode_d),
    .valid_d(valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [31:0] i, input logic [31:0] p,
    input logic [31:0] p8, input logic b,
    input logic [4:0] x, input logic v);
    exp_t e;
    e.instr = i; e.pc = p; e.pc8 = p8;
    e.bd = b; e.exc = x; e.valid = v;
    return e;
  endfunction

  int vec = 0;

  task automatic step(
    input logic rs, input logic fl,
    input logic st, input logic xs,
    input logic jm, input logic [31:0] pc,
    input logic [31:0] ins, input exp_t e);
    @(negedge clk);
    reset = rs; flush = fl; stall = st;
    xstall = xs; is_jump_d = jm;
    pc_f = pc; instr_f = ins;
    q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, sampled just after the edge.
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = q.pop_front();
      a = mk(instr_d, pc_d, pc8_d, bd_d, exccode_d, valid_d);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL vec%0d got i=%h pc=%h pc8=%h bd=%b exc=%0d v=%b want i=%h pc=%h pc8=%h bd=%b exc=%0d v=%b",
          vec, a.instr, a.pc, a.pc8, a.bd, a.exc, a.valid,
          e.instr, e.pc, e.pc8, e.bd, e.exc, e.valid);
      end
      vec++;
    end
  end

  exp_t rst_e, ld1, ld15, bad_e;

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0;
    xstall = 1'b0; is_jump_d = 1'b0;
    pc_f = 32'h0; instr_f = 32'h0;

    rst_e = mk(32'h0, 32'h3000, 32'h3008, 0, 0, 0);
    ld1   = mk(32'h24080001, 32'h3004, 32'h300C, 0, 0, 1);

    step(1, 0, 0, 0, 0, 32'h3000, 32'h0, rst_e);
    step(0, 0, 0, 0, 0, 32'h3004, 32'h24080001, ld1);
    step(0, 0, 1, 0, 0, 32'h3008, 32'h1, ld1);
    step(0, 0, 1, 0, 1, 32'h300C, 32'h2, ld1);
    step(0, 0, 1, 0, 0, 32'h3010, 32'h3, ld1);
    step(0, 0, 0, 1, 1, 32'h3014, 32'h4, ld1);
    step(0, 0, 0, 1, 0, 32'h3018, 32'h5, ld1);
    step(0, 0, 0, 0, 0, 32'h301C, 32'h2409000A,
         mk(32'h2409000A, 32'h301C, 32'h3024, 0, 0, 1));
    step(0, 1, 1, 0, 1, 32'h3010, 32'hDEADBEEF,
         mk(32'h0, 32'h3010, 32'h3018, 0, 0, 0));
    step(0, 0, 0, 0, 1, 32'h3020, 32'h10000003,
         mk(32'h10000003, 32'h3020, 32'h3028, 1, 0, 1));
    step(0, 0, 0, 0, 0, 32'h3024, 32'h8C0A0000,
         mk(32'h8C0A0000, 32'h3024, 32'h302C, 0, 0, 1));
    step(0, 0, 0, 0, 1, 32'h3028, 32'h00000001,
         mk(32'h1, 32'h3028, 32'h3030, 1, 0, 1));
    step(0, 0, 1, 0, 0, 32'h302C, 32'h7,
         mk(32'h1, 32'h3028, 32'h3030, 1, 0, 1));
    step(0, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h11111111,
         EXC ? mk(32'h0, 32'hFFFFFFFC, 32'h4, 0, 4, 1)
             : mk(32'h11111111, 32'hFFFFFFFC, 32'h4, 0, 0, 1));
    ld15 = EXC ? mk(32'h0, 32'h3002, 32'h300A, 0, 4, 1)
               : mk(32'h12345678, 32'h3002, 32'h300A, 0, 0, 1);
    step(0, 0, 0, 0, 0, 32'h3002, 32'h12345678, ld15);
    step(0, 0, 0, 1, 0, 32'h3040, 32'h9, ld15);
    step(0, 0, 0, 0, 0, 32'h5000, 32'hABCD0000,
         EXC ? mk(32'h0, 32'h5000, 32'h5008, 0, 4, 1)
             : mk(32'hABCD0000, 32'h5000, 32'h5008, 0, 0, 1));
    step(0, 0, 0, 0, 1, 32'h4FFC, 32'hCAFEBABE,
         mk(32'hCAFEBABE, 32'h4FFC, 32'h5004, 1, 0, 1));
    bad_e = EXC ? mk(32'h0, 32'h2FFC, 32'h3004, 0, 4, 1)
                : mk(32'h1, 32'h2FFC, 32'h3004, 0, 0, 1);
    step(0, 0, 0, 0, 0, 32'h2FFC, 32'h1, bad_e);
    step(0, 1, 0, 0, 1, 32'h3001, 32'h5,
         mk(32'h0, 32'h3001, 32'h3009, 0, 0, 0));
    step(0, 0, 0, 0, 0, 32'h3044, 32'h6,
         mk(32'h6, 32'h3044, 32'h304C, 0, 0, 1));
    step(1, 0, 1, 0, 1, 32'h3048, 32'h7, rst_e);
    step(0, 0, 0, 0, 0, 32'h3000, 32'h3C011234,
         mk(32'h3C011234, 32'h3000, 32'h3008, 0, 0, 1));
    step(1, 1, 0, 1, 1, 32'h304C, 32'h8, rst_e);

    @(negedge clk);
    reset = 1'b0; stall = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
